arena_move_arbiter: RTL

- Owns the live 10x10 arena bitmap (bit index = row*10+col, 1 = wall/block) after the initializer loads it.
- Arbitrates movement and bomb requests from player A and player B round-robin, with one shared bomb slot.
- Runs the bomb fuse and clears destructible cells on explosion.
- Sits between the input/player logic and the VGA renderer; the renderer reads arena, pos_a, pos_b and bomb_pos.

---
 rtl/arena_move_arbiter.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/arena_move_arbiter.sv
// arena_move_arbiter: owns the live 10x10 arena bitmap and arbitrates move and
// bomb requests from two players round-robin. It also runs the single bomb slot
// and its fuse, and clears the non-border cells around the bomb when it explodes.
//
// Ports:
//   clk, rst                  clock (rising edge) and async active-high reset
//   init_valid, arena_init    one-cycle load of the initial arena bitmap
//   req_x, dir_x, bomb_x      per-player move/bomb request, held until grant_x
//   grant_a, grant_b          one-cycle pulse when a request is consumed
//   moved                     with a grant: move committed or bomb placed
//   arena, pos_a, pos_b       live bitmap and player cell indices
//   bomb_active, bomb_pos     bomb slot state
//   hit_a, hit_b              sticky: player was caught in an explosion
//   busy                      high in WAIT_INIT, EVAL and EXPLODE
module arena_move_arbiter #(
   parameter int unsigned FUSE_CYCLES = 16,
   parameter int unsigned POS_A_INIT  = 11,
   parameter int unsigned POS_B_INIT  = 88
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         init_valid,
   input  logic [99:0]  arena_init,
   input  logic         req_a,
   input  logic [1:0]   dir_a,
   input  logic         bomb_a,
   input  logic         req_b,
   input  logic [1:0]   dir_b,
   input  logic         bomb_b,
   output logic         grant_a,
   output logic         grant_b,
   output logic         moved,
   output logic [99:0]  arena,
   output logic [6:0]   pos_a,
   output logic [6:0]   pos_b,
   output logic         bomb_active,
   output logic [6:0]   bomb_pos,
   output logic         hit_a,
   output logic         hit_b,
   output logic         busy
);

   localparam int unsigned CELLS = 100;
   localparam int unsigned PW    = 7;
   localparam int unsigned FW    = 8;

   typedef enum logic [1:0] {WAIT_INIT, IDLE, EVAL, EXPLODE} state_t;

   // Mask of row 0, row 9, col 0 and col 9: these cells are never cleared.
   function automatic logic [CELLS-1:0] border_mask();
      logic [CELLS-1:0] m;
      m = '0;
      for (int unsigned r = 0; r < 10; r++)
         for (int unsigned c = 0; c < 10; c++)
            if (r == 0 || r == 9 || c == 0 || c == 9)
               m[PW'(r*10 + c)] = 1'b1;
      return m;
   endfunction

   localparam logic [CELLS-1:0] BORDER = border_mask();

   state_t          state;
   logic [FW-1:0]   fuse;
   logic            pend;
   logic            rr_b;        // 1: player B preferred on a tie
   logic            sel_b;
   logic            sel_bomb;
   logic [1:0]      sel_dir;

   logic            act_a, act_b, pick_b;
   logic [PW-1:0]   sel_pos, oth_pos, target;
   logic            sel_hit, move_ok;
   logic [PW-1:0]   cells [5];
   logic [CELLS-1:0] clr_mask;
   logic            blast_a, blast_b;

   // Arbitration: bomb or move pending per player, rr pointer breaks ties.
   always_comb begin
      act_a  = req_a | bomb_a;
      act_b  = req_b | bomb_b;
      pick_b = act_b & (~act_a | rr_b);
   end

   // Move evaluation for the latched player.
   always_comb begin
      sel_pos = sel_b ? pos_b : pos_a;
      oth_pos = sel_b ? pos_a : pos_b;
      sel_hit = sel_b ? hit_b : hit_a;
      target  = sel_pos;
      case (sel_dir)
         2'd0: target = sel_pos - PW'(10);
         2'd1: target = sel_pos + PW'(10);
         2'd2: target = sel_pos - PW'(1);
         2'd3: target = sel_pos + PW'(1);
      endcase
      move_ok = ~arena[target] & (target != oth_pos) &
                ~(bomb_active & (target == bomb_pos));
   end

   // Blast footprint: bomb cell plus its four neighbours.
   always_comb begin
      cells[0] = bomb_pos;
      cells[1] = bomb_pos - PW'(10);
      cells[2] = bomb_pos + PW'(10);
      cells[3] = bomb_pos - PW'(1);
      cells[4] = bomb_pos + PW'(1);
      clr_mask = '0;
      blast_a  = 1'b0;
      blast_b  = 1'b0;
      for (int i = 0; i < 5; i++) begin
         clr_mask[cells[i]] = 1'b1;
         blast_a = blast_a | (pos_a == cells[i]);
         blast_b = blast_b | (pos_b == cells[i]);
      end
   end

   // Control FSM, fuse and all registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= WAIT_INIT;
         arena       <= '0;
         pos_a       <= PW'(POS_A_INIT);
         pos_b       <= PW'(POS_B_INIT);
         bomb_active <= 1'b0;
         bomb_pos    <= '0;
         fuse        <= '0;
         pend        <= 1'b0;
         hit_a       <= 1'b0;
         hit_b       <= 1'b0;
         grant_a     <= 1'b0;
         grant_b     <= 1'b0;
         moved       <= 1'b0;
         rr_b        <= 1'b0;
         sel_b       <= 1'b0;
         sel_bomb    <= 1'b0;
         sel_dir     <= '0;
         busy        <= 1'b1;
      end else begin
         grant_a <= 1'b0;
         grant_b <= 1'b0;
         moved   <= 1'b0;

         // Fuse runs in every state; expiry is serviced from IDLE.
         if (bomb_active && !pend) begin
            if (fuse <= FW'(1)) begin
               fuse <= '0;
               pend <= 1'b1;
            end else begin
               fuse <= fuse - FW'(1);
            end
         end

         case (state)
            WAIT_INIT: begin
               if (init_valid) begin
                  arena <= arena_init;
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end

            IDLE: begin
               if (pend) begin
                  state <= EXPLODE;
                  busy  <= 1'b1;
               end else if (act_a || act_b) begin
                  sel_b    <= pick_b;
                  sel_bomb <= pick_b ? bomb_b : bomb_a;
                  sel_dir  <= pick_b ? dir_b : dir_a;
                  state    <= EVAL;
                  busy     <= 1'b1;
               end
            end

            EVAL: begin
               state   <= IDLE;
               busy    <= 1'b0;
               grant_a <= ~sel_b;
               grant_b <= sel_b;
               rr_b    <= ~sel_b;
               // A player already hit is granted without effect.
               if (!sel_hit) begin
                  if (sel_bomb) begin
                     if (!bomb_active) begin
                        bomb_active <= 1'b1;
                        bomb_pos    <= sel_pos;
                        fuse        <= FW'(FUSE_CYCLES);
                        moved       <= 1'b1;
                     end
                  end else if (move_ok) begin
                     if (sel_b) pos_b <= target;
                     else       pos_a <= target;
                     moved <= 1'b1;
                  end
               end
            end

            EXPLODE: begin
               arena       <= arena & ~(clr_mask & ~BORDER);
               hit_a       <= hit_a | blast_a;
               hit_b       <= hit_b | blast_b;
               bomb_active <= 1'b0;
               pend        <= 1'b0;
               state       <= IDLE;
               busy        <= 1'b0;
            end

            default: begin
               state <= WAIT_INIT;
               busy  <= 1'b1;
            end
         endcase
      end
   end

endmodule
